// File: rtl/kp_pkg.sv
// Shared sizes, entry field positions and FSM encodings
// for the keypoint buffer controller.
package kp_pkg;
   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int DW    = 47;
   localparam int DSTW  = 14;

   localparam int ROW_MSB   = 46;
   localparam int ROW_LSB   = 38;
   localparam int COL_MSB   = 37;
   localparam int COL_LSB   = 28;
   localparam int DIST_MSB  = 27;
   localparam int DIST_LSB  = 14;
   localparam int DIST2_MSB = 13;
   localparam int DIST2_LSB = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      UPD_WR = 1'b1
   } fsm_t;

   typedef enum logic {
      PRIO_PUSH = 1'b0,
      PRIO_UPD  = 1'b1
   } prio_t;
endpackage

// File: rtl/kp_pop_skid.sv
// Two-entry registered skid holding prefetched head entries,
// with a credit flag saying a new read may be issued.
module kp_pop_skid
   import kp_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          pop_ready,
   output logic          pop_valid,
   output logic [DW-1:0] pop_data,
   output logic [1:0]    occ,
   output logic          credit
);
   logic [DW-1:0] d0, d1;
   logic [1:0]    occ_q;
   logic          pop_fire;

   assign pop_valid = (occ_q != 2'd0);
   assign pop_data  = d0;
   assign occ       = occ_q;
   assign pop_fire  = pop_valid & pop_ready;
   // a read issued now lands next cycle; count it against the slots
   assign credit = ({1'b0, occ_q} + {2'b0, load})
                 < (3'd2 + {2'b0, pop_fire});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= 2'd0;
         d0    <= '0;
         d1    <= '0;
      end else if (clear) begin
         occ_q <= 2'd0;
      end else begin
         unique case ({load, pop_fire})
            2'b10: begin
               if (occ_q == 2'd0) d0 <= load_data;
               else               d1 <= load_data;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               d0    <= d1;
               occ_q <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  d0 <= load_data;
               end else begin
                  d0 <= d1;
                  d1 <= load_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/kp_buf_ctrl.sv
// Circular-queue controller for the 512x47 keypoint buffer:
// push/update arbitration on port 1, in-order prefetch on port 2.
module kp_buf_ctrl
   import kp_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            push_valid,
   output logic            push_ready,
   input  logic [DW-1:0]   push_data,
   input  logic            upd_valid,
   output logic            upd_ready,
   input  logic [AW-1:0]   upd_idx,
   input  logic [DSTW-1:0] upd_dist,
   output logic            upd_err,
   output logic            pop_valid,
   input  logic            pop_ready,
   output logic [DW-1:0]   pop_data,
   output logic [AW:0]     count,
   output logic            full,
   output logic            empty,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr1,
   output logic [AW-1:0]   mem_addr2,
   output logic [DW-1:0]   mem_din,
   input  logic [DW-1:0]   mem_dout1,
   input  logic [DW-1:0]   mem_dout2
);
   fsm_t            state, state_n;
   prio_t           prio;
   logic [AW:0]     wr_ptr, iss_ptr, fill;
   logic            inflight, credit, ok;
   logic [1:0]      occ;
   logic [AW-1:0]   idx_q;
   logic [DSTW-1:0] dist_q;
   logic            inwin_q, win_now, in_upd, upd_wr;
   logic            push_req, push_fire, upd_fire;
   logic            issue, hazard;
   logic [DW-1:0]   upd_ent;
   logic [DSTW-1:0] old_d, old_d2;

   function automatic logic in_win(
      input logic [AW-1:0] idx,
      input logic [AW:0]   iss,
      input logic [AW:0]   f
   );
      logic [AW-1:0] off;
      off = idx - iss[AW-1:0];
      return ({1'b0, off} < f);
   endfunction

   assign ok       = rst_n & ~clear;
   assign fill     = wr_ptr - iss_ptr;
   assign full     = (fill == (AW+1)'(DEPTH));
   assign push_req = push_valid & ~full;

   assign push_ready = ok & (state == IDLE) & ~full
                     & ~(upd_valid & (prio == PRIO_UPD));
   assign upd_ready  = ok & (state == IDLE)
                     & ~(push_req & (prio == PRIO_PUSH));
   assign push_fire  = push_valid & push_ready;
   assign upd_fire   = upd_valid & upd_ready;

   assign old_d   = mem_dout1[DIST_MSB:DIST_LSB];
   assign old_d2  = mem_dout1[DIST2_MSB:DIST2_LSB];
   assign win_now = in_win(idx_q, iss_ptr, fill);
   assign in_upd  = ok & (state == UPD_WR);
   assign upd_wr  = in_upd & inwin_q & win_now;
   assign upd_err = in_upd & ~(inwin_q & win_now);

   always_comb begin
      upd_ent = mem_dout1;
      if (dist_q < old_d) begin
         upd_ent[DIST2_MSB:DIST2_LSB] = old_d;
         upd_ent[DIST_MSB:DIST_LSB]   = dist_q;
      end else if (dist_q < old_d2) begin
         upd_ent[DIST2_MSB:DIST2_LSB] = dist_q;
      end
   end

   // hold off reading the entry being written back so the skid gets new data
   assign hazard = upd_wr & (iss_ptr[AW-1:0] == idx_q);
   assign issue  = ok & (fill != '0) & credit & ~hazard;

   assign mem_we    = push_fire | upd_wr;
   assign mem_addr2 = iss_ptr[AW-1:0];
   assign mem_din   = upd_wr ? upd_ent
                    : (push_fire ? push_data : '0);

   always_comb begin
      mem_addr1 = wr_ptr[AW-1:0];
      if (state == UPD_WR) mem_addr1 = idx_q;
      else if (upd_fire)   mem_addr1 = upd_idx;
   end

   assign count = fill + {{AW{1'b0}}, inflight}
                + {{(AW-1){1'b0}}, occ};
   assign empty = (count == '0);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (upd_fire) state_n = UPD_WR;
         UPD_WR:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (clear) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         iss_ptr  <= '0;
         inflight <= 1'b0;
         prio     <= PRIO_PUSH;
         idx_q    <= '0;
         dist_q   <= '0;
         inwin_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         iss_ptr  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + 1'b1;
         if (issue)     iss_ptr <= iss_ptr + 1'b1;
         inflight <= issue;
         if (upd_fire) begin
            idx_q   <= upd_idx;
            dist_q  <= upd_dist;
            inwin_q <= in_win(upd_idx, iss_ptr, fill);
         end
         if ((state == IDLE) & push_req & upd_valid)
            prio <= (prio == PRIO_PUSH) ? PRIO_UPD : PRIO_PUSH;
      end
   end

   kp_pop_skid u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .load      (inflight),
      .load_data (mem_dout2),
      .pop_ready (pop_ready),
      .pop_valid (pop_valid),
      .pop_data  (pop_data),
      .occ       (occ),
      .credit    (credit)
   );
endmodule

// File: tb/tb_kp_buf_ctrl.sv
// Scoreboard bench for kp_buf_ctrl with a behavioural
// 512x47 dual-port memory beside the controller.
module tb_kp_buf_ctrl;
   import kp_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n, clear;
   logic            push_valid, push_ready;
   logic [DW-1:0]   push_data;
   logic            upd_valid, upd_ready, upd_err;
   logic [AW-1:0]   upd_idx;
   logic [DSTW-1:0] upd_dist;
   logic            pop_valid, pop_ready;
   logic [DW-1:0]   pop_data;
   logic [AW:0]     count;
   logic            full, empty, mem_we;
   logic [AW-1:0]   mem_addr1, mem_addr2;
   logic [DW-1:0]   mem_din, mem_dout1, mem_dout2;

   logic [DW-1:0]   mem [DEPTH];
   logic [DW-1:0]   exp_q [$];
   int              tests = 0;
   int              fails = 0;
   int              cyc = 0;
   int              first_pv = -1;

   always #5 clk = ~clk;

   kp_buf_ctrl dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_data(push_data),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_idx(upd_idx), .upd_dist(upd_dist), .upd_err(upd_err),
      .pop_valid(pop_valid), .pop_ready(pop_ready),
      .pop_data(pop_data),
      .count(count), .full(full), .empty(empty),
      .mem_we(mem_we), .mem_addr1(mem_addr1),
      .mem_addr2(mem_addr2), .mem_din(mem_din),
      .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr1] <= mem_din;
      mem_dout1 <= mem[mem_addr1];
      mem_dout2 <= mem[mem_addr2];
      cyc <= cyc + 1;
   end

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int r, input int c,
                                        input int d, input int d2);
      return {r[8:0], c[9:0], d[13:0], d2[13:0]};
   endfunction

   // monitor: every accepted pop is compared against the queue head
   always @(negedge clk) begin
      if (rst_n && pop_valid && first_pv < 0) first_pv = cyc;
      if (rst_n && pop_valid && pop_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got %0h expected none",
                     pop_data);
         end else begin
            check("pop_data", pop_data, exp_q.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit chk);
      rst_n = 1'b0; clear = 1'b0;
      push_valid = 1'b0; push_data = '0;
      upd_valid = 1'b0; upd_idx = '0; upd_dist = '0;
      pop_ready = 1'b0;
      repeat (2) tick();
      if (chk) begin
         @(negedge clk);
         check("rst_push_ready", push_ready, 0);
         check("rst_upd_ready", upd_ready, 0);
         check("rst_pop_valid", pop_valid, 0);
         check("rst_count", count, 0);
         check("rst_full", full, 0);
         check("rst_empty", empty, 1);
         check("rst_mem_we", mem_we, 0);
         check("rst_mem_din", mem_din, 0);
      end
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      tick();
   endtask

   task automatic push(input logic [DW-1:0] d);
      int n = 0;
      push_valid = 1'b1;
      push_data  = d;
      @(negedge clk);
      while (!push_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!push_ready) check("push_timeout", n, 0);
      else exp_q.push_back(d);
      tick();
      push_valid = 1'b0;
   endtask

   task automatic update(input logic [AW-1:0] idx,
                         input logic [DSTW-1:0] d,
                         input logic exp_err);
      int n = 0;
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_dist  = d;
      @(negedge clk);
      while (!upd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!upd_ready) check("upd_timeout", n, 0);
      tick();
      upd_valid = 1'b0;
      @(negedge clk);
      check("upd_err", upd_err, exp_err);
      check("upd_we", mem_we, !exp_err);
      tick();
   endtask

   task automatic drain;
      int n = 0;
      pop_ready = 1'b1;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("drain_empty", empty, 1);
      tick();
      pop_ready = 1'b0;
   endtask

   int expg [9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};

   initial begin
      int t_push, g;
      // ordered pops and first-pop latency
      do_reset(1'b1);
      pop_ready = 1'b1;
      first_pv = -1;
      push(mk(1, 11, 5, 6));
      t_push = cyc;
      push(mk(2, 12, 5, 6));
      push(mk(3, 13, 5, 6));
      drain();
      check("first_pop_latency", first_pv - t_push, 2);

      // fill to full with pops stalled, then one pop frees a slot
      do_reset(1'b0);
      for (int i = 0; i < 514; i++) begin
         push(mk(i & 511, i, 1, 2));
         if (i == 511) begin
            @(negedge clk);
            check("cnt_512", count, 512);
            check("full_512", full, 0);
            tick();
         end
      end
      @(negedge clk);
      check("full_cnt", count, 514);
      check("full_flag", full, 1);
      tick();
      push_valid = 1'b1;
      push_data  = mk(2, 514, 1, 2);
      @(negedge clk);
      check("full_push_ready", push_ready, 0);
      check("full_no_we", mem_we, 0);
      tick();
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      @(negedge clk);
      check("unfull", full, 0);
      check("cnt_after_pop", count, 513);
      check("push_resume", push_ready, 1);
      check("wrap_addr", mem_addr1, 2);
      check("wrap_we", mem_we, 1);
      exp_q.push_back(push_data);
      tick();
      push_valid = 1'b0;
      drain();

      // dist/dist2 updates and out-of-window rejection
      do_reset(1'b0);
      push(mk(1, 11, 100, 200));
      push(mk(2, 22, 100, 200));
      push(mk(3, 33, 100, 200));
      repeat (4) tick();
      update(9'd0, 14'd10, 1'b1);
      check("mem0_kept", mem[0], mk(1, 11, 100, 200));
      update(9'd2, 14'd50, 1'b0);
      check("upd50", mem[2], mk(3, 33, 50, 100));
      update(9'd2, 14'd150, 1'b0);
      check("upd150", mem[2], mk(3, 33, 50, 100));
      update(9'd2, 14'd70, 1'b0);
      check("upd70", mem[2], mk(3, 33, 50, 70));
      exp_q[2] = mk(3, 33, 50, 70);
      drain();

      // contending push and update alternate grants
      do_reset(1'b0);
      pop_ready  = 1'b1;
      push_valid = 1'b1;
      push_data  = mk(100, 0, 3, 4);
      upd_valid  = 1'b1;
      upd_idx    = 9'd300;
      upd_dist   = 14'd1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         g = (push_valid && push_ready) ? 1
           : ((upd_valid && upd_ready) ? 2 : 0);
         check("grant", g, expg[k]);
         if (g == 1) exp_q.push_back(push_data);
         tick();
         if (g == 1) push_data = mk(101 + k, k, 3, 4);
      end
      push_valid = 1'b0;
      upd_valid  = 1'b0;
      drain();

      // async reset in the write-back cycle
      do_reset(1'b0);
      push(mk(7, 1, 100, 200));
      push(mk(8, 2, 100, 200));
      push(mk(9, 3, 100, 200));
      repeat (4) tick();
      upd_valid = 1'b1;
      upd_idx   = 9'd2;
      upd_dist  = 14'd5;
      @(negedge clk);
      check("rmw_rst_accept", upd_ready, 1);
      tick();
      upd_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("rmw_rst_we", mem_we, 0);
      check("rmw_rst_empty", empty, 1);
      check("rmw_rst_count", count, 0);
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      tick();
      check("rmw_rst_mem", mem[2], mk(9, 3, 100, 200));
      pop_ready = 1'b1;
      push(mk(20, 5, 6, 7));
      drain();

      // clear in the write-back cycle
      do_reset(1'b0);
      push(mk(10, 1, 100, 200));
      push(mk(11, 2, 100, 200));
      push(mk(12, 3, 100, 200));
      repeat (4) tick();
      upd_valid = 1'b1;
      upd_idx   = 9'd2;
      upd_dist  = 14'd5;
      @(negedge clk);
      check("rmw_clr_accept", upd_ready, 1);
      tick();
      upd_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      check("clr_we", mem_we, 0);
      check("clr_upd_ready", upd_ready, 0);
      check("clr_push_ready", push_ready, 0);
      check("clr_upd_err", upd_err, 0);
      tick();
      clear = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("clr_empty", empty, 1);
      check("clr_count", count, 0);
      check("clr_mem", mem[2], mk(12, 3, 100, 200));
      tick();
      pop_ready = 1'b1;
      first_pv = -1;
      push(mk(30, 9, 8, 7));
      t_push = cyc;
      drain();
      check("clr_fresh_latency", first_pv - t_push, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule
